fpu_issue_ctrl: RTL and testbench
=================================

Name: fpu_issue_ctrl

Overview:
Issuing end of the FPU_S operand/start/busy interface. Accepts one FP instruction at a time from decode and drives operands, funct5 and resolved rounding mode to the FPU. Pulses start, waits for busy low, then captures result and exception flags. Owns the fcsr state (frm, sticky fflags) and presents the result to writeback with a valid/ready handshake.

Parameters:
FLEN, 32, operand/result width (single precision only).
TIMEOUT_CYCLES, 64, watchdog limit on busy; used only with FPU_TIMEOUT_EN.

Ports:
clk  in  1  clock, rising edge
rstLow  in  1  asynchronous active-low reset
valid_i  in  1  decode presents an FP instruction
ready_o  out  1  controller can accept (high only in IDLE)
rs1_i / rs2_i / rs3_i  in  FLEN each  source operands
funct5_i  in  5  FPU operation selector
rm_i  in  3  instruction rounding field (111 = dynamic)
rd_i  in  5  destination register index
fpu_rs1_o / fpu_rs2_o / fpu_rs3_o  out  FLEN each  registered operands to FPU
fpu_funct5_o  out  5  registered operation
fpu_frm_o  out  3  resolved rounding mode
fpu_start_o  out  1  one-cycle start pulse
fpu_c_i  in  FLEN  FPU result
fpu_fflags_i  in  5  FPU flags {NV,DZ,OF,UF,NX}
fpu_busy_i  in  1  FPU multi-cycle op ongoing
wb_valid_o  out  1  result available
wb_ready_i  in  1  writeback accepts
wb_rd_o  out  5  destination index
wb_data_o  out  FLEN  result
wb_illegal_o  out  1  instruction rejected (illegal rounding mode)
csr_we_i  in  1  fcsr write strobe
csr_wdata_i  in  8  {frm[2:0], fflags[4:0]}
csr_rdata_o  out  8  current {frm, fflags}

Behaviour:
- Reset (rstLow low, async): state IDLE; all registered outputs 0; frm=000, fflags=00000; ready_o=1.
- States: IDLE, ISSUE, WAIT, WB.
- IDLE: ready_o=1. On valid_i, register operands, funct5, rd and resolved rm:
  - rm_i != 111 -> rm_i; rm_i == 111 -> fcsr frm.
  - Resolved rm in {101,110,111} is illegal: go to WB with wb_illegal_o=1, wb_data_o=0, no start pulse, fflags unchanged.
  - Otherwise go to ISSUE.
- ISSUE (1 cycle): fpu_start_o=1.
  - fpu_busy_i=0 this cycle -> capture fpu_c_i/fpu_fflags_i, go to WB.
  - fpu_busy_i=1 -> go to WAIT.
- WAIT: fpu_start_o=0; operand outputs held stable. First cycle with fpu_busy_i=0 -> capture, go to WB.
- Latency: combinational FPU gives wb_valid_o two cycles after acceptance.
- Capture: fflags <= fflags | fpu_fflags_i (sticky); wb_data_o <= fpu_c_i.
- WB: wb_valid_o=1 with wb_rd_o/wb_data_o/wb_illegal_o stable until wb_ready_i=1, then IDLE. ready_o is 0 during WB, so the next instruction is accepted only on the following cycle.
- CSR write: takes effect at the clock edge. Same-cycle capture: fflags <= csr_wdata_i[4:0] | fpu_fflags_i, so no exception is lost. frm from a CSR write affects only instructions accepted after that edge.
- csr_rdata_o is the registered value with no bypass.
- Reset mid-operation: immediate IDLE, no wb_valid_o, fcsr cleared.
- fpu_busy_i ignored in IDLE and WB.

Optional Feature:
FPU_TIMEOUT_EN
- Defined: counter cleared on entering WAIT, increments each WAIT cycle. On reaching TIMEOUT_CYCLES with busy still high:
  - abort to WB with wb_data_o=32'h7FC00000;
  - fflags NV set sticky;
  - wb_illegal_o=0.
- Undefined: no counter; WAIT lasts indefinitely.

Test Plan:
1. rs1=3F800000, rs2=40000000, FADD, rm=000, busy=0 -> accept t, start pulse t+1 only, wb_valid t+2 with data 40400000, fflags 00000.
2. CSR write 0x60 (frm=011), then instr rm=111 -> fpu_frm_o=011. Instr rm=010 -> fpu_frm_o=010.
3. rm_i=101, or rm=111 with frm=110 -> no fpu_start_o, wb_illegal_o=1, wb_data_o=0, fflags unchanged.
4. FPU returns flags 10000 then 00001 -> csr_rdata_o[4:0]=10001. CSR write 0x00 in the same cycle as a capture of 00001 -> fflags=00001.
5. busy held high 3 cycles after start -> WAIT, capture on busy low. wb_ready_i low 2 cycles -> wb outputs held; IDLE after handshake. rstLow pulsed in WAIT -> IDLE, no wb_valid_o.
6. FPU_TIMEOUT_EN, busy stuck high -> after 64 WAIT cycles, wb_data_o=7FC00000, fflags[4]=1.

Source files
------------

// File: rtl/fpu_issue_ctrl.sv
// FP issue controller: hands one instruction at a time to an FPU and owns fcsr (frm, sticky fflags).
// Optional macro FPU_TIMEOUT_EN adds a busy watchdog that aborts a hung operation with a canonical NaN.
module fpu_issue_ctrl #(
  parameter int FLEN           = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic            clk,
  input  logic            rstLow,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [FLEN-1:0] rs1_i,
  input  logic [FLEN-1:0] rs2_i,
  input  logic [FLEN-1:0] rs3_i,
  input  logic [4:0]      funct5_i,
  input  logic [2:0]      rm_i,
  input  logic [4:0]      rd_i,
  output logic [FLEN-1:0] fpu_rs1_o,
  output logic [FLEN-1:0] fpu_rs2_o,
  output logic [FLEN-1:0] fpu_rs3_o,
  output logic [4:0]      fpu_funct5_o,
  output logic [2:0]      fpu_frm_o,
  output logic            fpu_start_o,
  input  logic [FLEN-1:0] fpu_c_i,
  input  logic [4:0]      fpu_fflags_i,
  input  logic            fpu_busy_i,
  output logic            wb_valid_o,
  input  logic            wb_ready_i,
  output logic [4:0]      wb_rd_o,
  output logic [FLEN-1:0] wb_data_o,
  output logic            wb_illegal_o,
  input  logic            csr_we_i,
  input  logic [7:0]      csr_wdata_i,
  output logic [7:0]      csr_rdata_o,
  output logic [1:0]      dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // wb_* stay stable while wb_valid_o is high and wb_ready_i is low.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_WB    = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] frm_q;
  logic [4:0] fflags_q, fflags_d;
  logic [2:0] rm_res;
  logic       rm_illegal;
  logic       accept;
  logic       capture;
  logic       timeout;

  assign rm_res      = (rm_i == 3'b111) ? frm_q : rm_i;
  assign rm_illegal  = (rm_res >= 3'd5);
  assign accept      = (state_q == S_IDLE) && valid_i;
  assign capture     = ((state_q == S_ISSUE) || (state_q == S_WAIT)) && !fpu_busy_i;
  assign csr_rdata_o = {frm_q, fflags_q};
  assign dbg_state_o = state_q;

`ifdef FPU_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] wait_cnt_q;

  // Counter reads zero on the first WAIT cycle, so the abort lands on WAIT cycle TIMEOUT_CYCLES.
  always_ff @(posedge clk or negedge rstLow) begin
    if (!rstLow)                wait_cnt_q <= '0;
    else if (state_q != S_WAIT) wait_cnt_q <= '0;
    else                        wait_cnt_q <= wait_cnt_q + 1'b1;
  end

  assign timeout = (state_q == S_WAIT) && fpu_busy_i && (wait_cnt_q == CNT_LAST);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstLow) begin
    if (!rstLow) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    ready_o     = 1'b0;
    fpu_start_o = 1'b0;
    wb_valid_o  = 1'b0;
    case (state_q)
      S_IDLE: begin
        ready_o = 1'b1;
        if (valid_i) state_d = rm_illegal ? S_WB : S_ISSUE;
      end
      S_ISSUE: begin
        fpu_start_o = 1'b1;
        state_d     = fpu_busy_i ? S_WAIT : S_WB;
      end
      S_WAIT: begin
        if (capture || timeout) state_d = S_WB;
      end
      S_WB: begin
        wb_valid_o = 1'b1;
        if (wb_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A CSR write and an FPU capture on the same edge merge, so no exception is dropped.
  always_comb begin
    fflags_d = csr_we_i ? csr_wdata_i[4:0] : fflags_q;
    if (capture)      fflags_d = fflags_d | fpu_fflags_i;
    else if (timeout) fflags_d = fflags_d | 5'b10000;
  end

  always_ff @(posedge clk or negedge rstLow) begin
    if (!rstLow) begin
      fpu_rs1_o    <= '0;
      fpu_rs2_o    <= '0;
      fpu_rs3_o    <= '0;
      fpu_funct5_o <= '0;
      fpu_frm_o    <= '0;
      wb_rd_o      <= '0;
      wb_data_o    <= '0;
      wb_illegal_o <= 1'b0;
      frm_q        <= '0;
      fflags_q     <= '0;
    end else begin
      if (accept) begin
        fpu_rs1_o    <= rs1_i;
        fpu_rs2_o    <= rs2_i;
        fpu_rs3_o    <= rs3_i;
        fpu_funct5_o <= funct5_i;
        fpu_frm_o    <= rm_res;
        wb_rd_o      <= rd_i;
        wb_illegal_o <= rm_illegal;
        wb_data_o    <= '0;
      end else if (capture) begin
        wb_data_o <= fpu_c_i;
      end else if (timeout) begin
        wb_data_o <= FLEN'(32'h7FC0_0000);
      end
      if (csr_we_i) frm_q <= csr_wdata_i[7:5];
      fflags_q <= fflags_d;
    end
  end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed and randomized bench for fpu_issue_ctrl; the bench plays the FPU and keeps an fcsr model.
module tb_fpu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rstLow;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] rs1_i, rs2_i, rs3_i;
  logic [4:0]  funct5_i;
  logic [2:0]  rm_i;
  logic [4:0]  rd_i;
  logic [31:0] fpu_rs1_o, fpu_rs2_o, fpu_rs3_o;
  logic [4:0]  fpu_funct5_o;
  logic [2:0]  fpu_frm_o;
  logic        fpu_start_o;
  logic [31:0] fpu_c_i;
  logic [4:0]  fpu_fflags_i;
  logic        fpu_busy_i;
  logic        wb_valid_o;
  logic        wb_ready_i;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic        wb_illegal_o;
  logic        csr_we_i;
  logic [7:0]  csr_wdata_i;
  logic [7:0]  csr_rdata_o;
  logic [1:0]  dbg_state_o;

  int errors = 0;
  int checks = 0;

  // fcsr reference state
  logic [2:0] frm_m;
  logic [4:0] fflags_m;

  fpu_issue_ctrl #(.FLEN(32), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rstLow(rstLow), .valid_i(valid_i), .ready_o(ready_o),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .rs3_i(rs3_i), .funct5_i(funct5_i),
    .rm_i(rm_i), .rd_i(rd_i),
    .fpu_rs1_o(fpu_rs1_o), .fpu_rs2_o(fpu_rs2_o), .fpu_rs3_o(fpu_rs3_o),
    .fpu_funct5_o(fpu_funct5_o), .fpu_frm_o(fpu_frm_o), .fpu_start_o(fpu_start_o),
    .fpu_c_i(fpu_c_i), .fpu_fflags_i(fpu_fflags_i), .fpu_busy_i(fpu_busy_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_rd_o(wb_rd_o),
    .wb_data_o(wb_data_o), .wb_illegal_o(wb_illegal_o),
    .csr_we_i(csr_we_i), .csr_wdata_i(csr_wdata_i), .csr_rdata_o(csr_rdata_o),
    .dbg_state_o(dbg_state_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic csr_write(input logic [7:0] v);
    csr_we_i    = 1'b1;
    csr_wdata_i = v;
    #1 check("csr_no_bypass", csr_rdata_o, {frm_m, fflags_m});
    step();
    csr_we_i = 1'b0;
    frm_m    = v[7:5];
    fflags_m = v[4:0];
    check("csr_write", csr_rdata_o, {frm_m, fflags_m});
  endtask

  // One instruction from acceptance to writeback handshake; busy_n = cycles busy stays high from ISSUE.
  task automatic run_instr(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                           input logic [4:0] f5, input logic [2:0] rm, input logic [4:0] rd,
                           input int busy_n, input int stall_n,
                           input logic [31:0] res, input logic [4:0] flg,
                           input logic csr_cap, input logic [7:0] csr_val);
    logic [2:0]  rres;
    logic        ill;
    logic [31:0] exp_data;
    rres     = (rm == 3'b111) ? frm_m : rm;
    ill      = (rres == 3'd5) || (rres == 3'd6) || (rres == 3'd7);
    exp_data = ill ? 32'h0 : res;
    check("idle_ready", ready_o, 1'b1);
    valid_i    = 1'b1;
    rs1_i      = a;
    rs2_i      = b;
    rs3_i      = c;
    funct5_i   = f5;
    rm_i       = rm;
    rd_i       = rd;
    fpu_busy_i = 1'($urandom_range(0, 1));
    step();
    valid_i  = 1'b0;
    rs1_i    = $urandom;
    rs2_i    = $urandom;
    rs3_i    = $urandom;
    funct5_i = 5'($urandom);
    rm_i     = 3'($urandom);
    rd_i     = 5'($urandom);
    if (ill) begin
      check("ill_no_start", fpu_start_o, 1'b0);
      check("ill_wb_valid", wb_valid_o, 1'b1);
      check("ill_flag", wb_illegal_o, 1'b1);
      check("ill_data", wb_data_o, 32'h0);
      check("ill_fcsr", csr_rdata_o, {frm_m, fflags_m});
    end else begin
      check("issue_start", fpu_start_o, 1'b1);
      check("issue_no_wb", wb_valid_o, 1'b0);
      check("issue_rs1", fpu_rs1_o, a);
      check("issue_rs2", fpu_rs2_o, b);
      check("issue_rs3", fpu_rs3_o, c);
      check("issue_funct5", fpu_funct5_o, f5);
      check("issue_frm", fpu_frm_o, rres);
      for (int k = 0; k <= busy_n; k++) begin
        if (k > 0) begin
          check("wait_no_start", fpu_start_o, 1'b0);
          check("wait_no_wb", wb_valid_o, 1'b0);
          check("wait_rs1_held", fpu_rs1_o, a);
          check("wait_frm_held", fpu_frm_o, rres);
        end
        fpu_busy_i = (k < busy_n);
        if (k == busy_n) begin
          fpu_c_i      = res;
          fpu_fflags_i = flg;
          csr_we_i     = csr_cap;
          csr_wdata_i  = csr_val;
        end else begin
          fpu_c_i      = $urandom;
          fpu_fflags_i = 5'($urandom);
        end
        step();
      end
      csr_we_i     = 1'b0;
      fpu_c_i      = $urandom;
      fpu_fflags_i = 5'($urandom);
      if (csr_cap) begin
        frm_m    = csr_val[7:5];
        fflags_m = csr_val[4:0] | flg;
      end else begin
        fflags_m = fflags_m | flg;
      end
      check("wb_valid", wb_valid_o, 1'b1);
      check("wb_data", wb_data_o, res);
      check("wb_legal", wb_illegal_o, 1'b0);
      check("wb_no_start", fpu_start_o, 1'b0);
      check("wb_fcsr", csr_rdata_o, {frm_m, fflags_m});
    end
    check("wb_rd", wb_rd_o, rd);
    check("wb_not_ready", ready_o, 1'b0);
    for (int s = 0; s < stall_n; s++) begin
      wb_ready_i = 1'b0;
      fpu_busy_i = 1'($urandom_range(0, 1));
      step();
      check("stall_valid", wb_valid_o, 1'b1);
      check("stall_data", wb_data_o, exp_data);
      check("stall_rd", wb_rd_o, rd);
      check("stall_illegal", wb_illegal_o, ill);
    end
    wb_ready_i = 1'b1;
    step();
    wb_ready_i = 1'b0;
    fpu_busy_i = 1'b0;
    check("post_wb_valid", wb_valid_o, 1'b0);
    check("post_wb_ready", ready_o, 1'b1);
  endtask

  initial begin
    rstLow = 1'b0; valid_i = 1'b0; rs1_i = '0; rs2_i = '0; rs3_i = '0;
    funct5_i = '0; rm_i = '0; rd_i = '0; fpu_c_i = '0; fpu_fflags_i = '0;
    fpu_busy_i = 1'b0; wb_ready_i = 1'b0; csr_we_i = 1'b0; csr_wdata_i = '0;
    frm_m = '0; fflags_m = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", ready_o, 1'b1);
    check("rst_wb_valid", wb_valid_o, 1'b0);
    check("rst_start", fpu_start_o, 1'b0);
    check("rst_csr", csr_rdata_o, 8'h00);
    check("rst_rs1", fpu_rs1_o, 32'h0);
    check("rst_wb_data", wb_data_o, 32'h0);
    rstLow = 1'b1;
    @(negedge clk);

    // FADD 1.0 + 2.0, combinational FPU
    run_instr(32'h3F80_0000, 32'h4000_0000, 32'h0, 5'b00000, 3'b000, 5'd1, 0, 0,
              32'h4040_0000, 5'b00000, 1'b0, 8'h00);
    check("t1_fflags", csr_rdata_o[4:0], 5'b00000);

    // Dynamic vs static rounding
    csr_write(8'h60);
    run_instr($urandom, $urandom, $urandom, 5'd1, 3'b111, 5'd2, 0, 0, $urandom, 5'b0, 1'b0, 8'h0);
    run_instr($urandom, $urandom, $urandom, 5'd2, 3'b010, 5'd3, 0, 0, $urandom, 5'b0, 1'b0, 8'h0);

    // Illegal rounding: static 101, then dynamic with frm=110
    run_instr($urandom, $urandom, $urandom, 5'd3, 3'b101, 5'd4, 0, 1, $urandom, 5'b0, 1'b0, 8'h0);
    csr_write(8'hC3);
    run_instr($urandom, $urandom, $urandom, 5'd3, 3'b111, 5'd5, 0, 0, $urandom, 5'b0, 1'b0, 8'h0);

    // Sticky flags, then CSR write colliding with a capture
    csr_write(8'h00);
    run_instr($urandom, $urandom, $urandom, 5'd4, 3'b001, 5'd6, 0, 0, $urandom, 5'b10000, 1'b0, 8'h0);
    run_instr($urandom, $urandom, $urandom, 5'd4, 3'b001, 5'd7, 0, 0, $urandom, 5'b00001, 1'b0, 8'h0);
    check("t4_sticky", csr_rdata_o[4:0], 5'b10001);
    run_instr($urandom, $urandom, $urandom, 5'd4, 3'b001, 5'd8, 2, 0, $urandom, 5'b00001, 1'b1, 8'h00);
    check("t4_collide", csr_rdata_o[4:0], 5'b00001);

    // Multi-cycle op with writeback back-pressure
    run_instr($urandom, $urandom, $urandom, 5'd5, 3'b011, 5'd9, 3, 2, $urandom, 5'b00100, 1'b0, 8'h0);

    // Reset asserted while waiting on busy
    csr_write(8'h5F);
    valid_i = 1'b1; rm_i = 3'b000; rd_i = 5'd10;
    step();
    valid_i = 1'b0; fpu_busy_i = 1'b1;
    step();
    step();
    check("pre_rst_wait", wb_valid_o, 1'b0);
    rstLow = 1'b0;
    #1;
    check("midrst_ready", ready_o, 1'b1);
    check("midrst_wb_valid", wb_valid_o, 1'b0);
    check("midrst_csr", csr_rdata_o, 8'h00);
    frm_m = '0; fflags_m = '0;
    @(negedge clk);
    rstLow = 1'b1; fpu_busy_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("post_rst_no_wb", wb_valid_o, 1'b0);
    end

    // Random mix against the fcsr model
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 4) == 0) csr_write(8'($urandom));
      run_instr($urandom, $urandom, $urandom, 5'($urandom), 3'($urandom_range(0, 7)),
                5'($urandom), $urandom_range(0, 4), $urandom_range(0, 2),
                $urandom, 5'($urandom), ($urandom_range(0, 5) == 0), 8'($urandom));
    end

`ifdef FPU_TIMEOUT_EN
    begin
      int n;
      logic [7:0] exp_csr;
      n = 0;
      csr_write(8'h00);
      valid_i = 1'b1; rm_i = 3'b000; rd_i = 5'd11;
      step();
      valid_i = 1'b0; fpu_busy_i = 1'b1;
      while (n < 200 && !wb_valid_o) begin
        step();
        n++;
      end
      check("to_reached", wb_valid_o, 1'b1);
      check("to_latency", n, 65);
      check("to_data", wb_data_o, 32'h7FC0_0000);
      check("to_illegal", wb_illegal_o, 1'b0);
      fflags_m = fflags_m | 5'b10000;
      exp_csr  = {frm_m, fflags_m};
      check("to_nv", csr_rdata_o, exp_csr);
      fpu_busy_i = 1'b0; wb_ready_i = 1'b1;
      step();
      wb_ready_i = 1'b0;
      check("to_idle", ready_o, 1'b1);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
